// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - fixed-latency byte-addressable data memory with load/store sizing
// Optional feature: define MISALIGN_CHECK_EN to reject misaligned or illegal accesses with rsp_err.
module data_mem_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 256,
    parameter int LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LO_W  = IDX_W + 2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]      cnt;
    logic                  cap_we;
    logic [2:0]            cap_f3;
    logic [LO_W-1:0]       cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;

    logic                  accept;
    logic                  commit;
    logic                  cur_we;
    logic [2:0]            cur_f3;
    logic [LO_W-1:0]       cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [IDX_W-1:0]      cur_idx;

    logic                  size_byte;
    logic                  size_half;
    logic                  access_err;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] rsp_data_nx;

    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Address bits above the word index are deliberately ignored (wrap-around).
    generate
        if (ADDRESS_WIDTH > LO_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDRESS_WIDTH-1:LO_W];
        end
    endgenerate

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign accept    = req_valid && (state == IDLE);

    // With LATENCY=1 the access completes on the accept edge, so use live inputs in IDLE.
    assign cur_we    = (state == IDLE) ? req_we              : cap_we;
    assign cur_f3    = (state == IDLE) ? req_funct3          : cap_f3;
    assign cur_addr  = (state == IDLE) ? req_addr[LO_W-1:0]  : cap_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata           : cap_wdata;
    assign cur_idx   = cur_addr[LO_W-1:2];

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nx = RESP;
                    commit   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign size_byte = (cur_f3[1:0] == 2'b00);
    assign size_half = (cur_f3[1:0] == 2'b01);

`ifdef MISALIGN_CHECK_EN
    assign access_err = (size_half && cur_addr[0])
                     || (!size_byte && !size_half && (cur_addr[1:0] != 2'b00))
                     || (cur_f3 == 3'b011)
                     || (cur_f3[2:1] == 2'b11)
                     || (cur_we && cur_f3[2]);
`else
    assign access_err = 1'b0;
`endif

    always_comb begin
        be = 4'b1111;
        wd = cur_wdata;
        if (size_byte) begin
            be = 4'b0001 << cur_addr[1:0];
            wd = {4{cur_wdata[7:0]}};
        end else if (size_half) begin
            be = cur_addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{cur_wdata[15:0]}};
        end
    end

    assign rd_word = mem[cur_idx];
    assign rd_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    assign rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        if (size_byte) begin
            load_val = cur_f3[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        end else if (size_half) begin
            load_val = cur_f3[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
        end
    end

    assign rsp_data_nx = (cur_we || access_err) ? '0 : load_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cap_we      <= 1'b0;
            cap_f3      <= '0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt       <= CNT_W'(LATENCY - 1);
                cap_we    <= req_we;
                cap_f3    <= req_funct3;
                cap_addr  <= req_addr[LO_W-1:0];
                cap_wdata <= req_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                rsp_rdata_q <= rsp_data_nx;
                rsp_err_q   <= access_err;
            end
        end
    end

    // Storage is intentionally not reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !access_err && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[cur_idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed scoreboard bench for data_mem_ctrl
module tb_data_mem_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];

    data_mem_ctrl #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .DEPTH_WORDS  (256),
        .LATENCY      (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wdat, input logic [31:0] er, input logic ee,
                         input bit push);
        if (push) exp_q.push_back({ee, er});
        @(negedge clk);
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wdat;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic finish_rsp(input int stall);
        int cyc;
        logic [32:0] e;
        @(negedge clk);
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(LAT));
        if (!rsp_valid) return;
        e = (exp_q.size() > 0) ? exp_q[0] : 33'h0;
        if (stall > 0) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'b010;
            req_addr   = 32'h10;
            req_wdata  = 32'hBAD0BAD0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("stall_valid", {31'h0, rsp_valid}, 32'h1);
                chk("stall_rdata", rsp_rdata, e[31:0]);
                chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e[31:0]);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (stall > 0) begin
            @(negedge clk);
            chk("post_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        end
    endtask

    task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wdat, input logic [31:0] er, input logic ee);
        issue(we, f3, a, wdat, er, ee, 1'b1);
        finish_rsp(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);

        xfer(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xfer(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        xfer(1'b1, 3'b010, 32'h10, 32'h00000000, 32'h0, 1'b0);
        xfer(1'b1, 3'b000, 32'h13, 32'hABCDEF80, 32'h0, 1'b0);
        xfer(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        xfer(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
        xfer(1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0);

        xfer(1'b1, 3'b001, 32'h12, 32'h1234BEEF, 32'h0, 1'b0);
        xfer(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0);
        xfer(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000BEEF, 1'b0);
        xfer(1'b0, 3'b100, 32'h10, 32'h0, 32'h00000000, 1'b0);
        xfer(1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFEF, 1'b0);

        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF0000, 1'b0, 1'b1);
        finish_rsp(5);
        xfer(1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF0000, 1'b0);

        xfer(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1'b0);
        xfer(1'b0, 3'b010, 32'h000, 32'h0, 32'hCAFEF00D, 1'b0);
        xfer(1'b1, 3'b010, 32'h3FC, 32'h0BADC0DE, 32'h0, 1'b0);
        xfer(1'b0, 3'b010, 32'h7FC, 32'h0, 32'h0BADC0DE, 1'b0);

        xfer(1'b1, 3'b010, 32'h20, 32'h1234A5C3, 32'h0, 1'b0);
        issue(1'b1, 3'b010, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("abort_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
        xfer(1'b0, 3'b010, 32'h20, 32'h0, 32'h1234A5C3, 1'b0);

`ifdef MISALIGN_CHECK_EN
        xfer(1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1);
        xfer(1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1);
        xfer(1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
        xfer(1'b0, 3'b010, 32'h20, 32'h0, 32'h1234A5C3, 1'b0);
`else
        xfer(1'b0, 3'b001, 32'h21, 32'h0, 32'hFFFFA5C3, 1'b0);
        xfer(1'b0, 3'b010, 32'h22, 32'h0, 32'h1234A5C3, 1'b0);
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
